// File: rtl/cache_pkg.sv
// Shared constants, state encoding and beat helper for the cache-to-RAM line bridge.
package cache_pkg;

  localparam int ADDR_SIZE       = 13;
  localparam int RAM_WORD_SIZE   = 16;
  localparam int CACHE_STR_WIDTH = 64;
  localparam int LINE_WIDTH      = CACHE_STR_WIDTH;
  localparam int BEATS           = LINE_WIDTH / RAM_WORD_SIZE;
  localparam int BEAT_W          = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_ACK  = 3'd4,
    DONE    = 3'd5
  } bridge_state_t;

  // Beat 0 is the least significant word of the line.
  function automatic logic [RAM_WORD_SIZE-1:0] line_beat(
    input logic [LINE_WIDTH-1:0] line,
    input logic [BEAT_W-1:0]     idx
  );
    return line[int'(idx)*RAM_WORD_SIZE +: RAM_WORD_SIZE];
  endfunction

endpackage

// File: rtl/ram_line_watchdog.sv
// Counts consecutive cycles without a RAM acknowledge while enabled; expired is
// raised on the edge at which the count would reach TIMEOUT.
module ram_line_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the FSM leaves on the same edge the count hits TIMEOUT.
  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_line_bridge.sv
// Turns one whole-line cache request into a multi-beat 16-bit RAM transaction,
// assembles read beats into a line, and aborts via watchdog on a silent RAM.
module ram_line_bridge
  import cache_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                     ram_clk,
  input  logic                     ram_rst,
  input  logic                     line_req,
  input  logic                     line_rnw,
  input  logic [ADDR_SIZE-1:0]     line_addr,
  input  logic [LINE_WIDTH-1:0]    line_wdata,
  output logic                     line_ready,
  output logic                     line_done,
  output logic                     line_err,
  output logic [LINE_WIDTH-1:0]    line_rdata,
  output logic [ADDR_SIZE-1:0]     ram_addr,
  output logic [RAM_WORD_SIZE-1:0] ram_wdata,
  output logic                     ram_avalid,
  output logic                     ram_rnw,
  input  logic [RAM_WORD_SIZE-1:0] ram_rdata,
  input  logic                     ram_rack,
  output bridge_state_t            dbg_state
);

  // Handshake: a request is taken on any edge where line_req=1 and line_ready=1;
  // the cache must drop line_req on line_done or it will be accepted again.
  // On the RAM side ram_avalid is presented without backpressure and ram_rack
  // is only meaningful in RD_DATA (one beat per ack) and WR_ACK (one ack).

  bridge_state_t             state, state_nxt;
  logic [BEAT_W-1:0]         beat;
  logic [LINE_WIDTH-1:0]     wdata_q;
  logic [RAM_WORD_SIZE-1:0]  wdata_nxt;
  logic                      accept;
  logic                      last_beat;
  logic                      wd_enable;
  logic                      wd_expired;

  assign accept    = (state == IDLE) && line_req;
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign wd_enable = (state == RD_DATA) || (state == WR_ACK);
  assign dbg_state = state;

  ram_line_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (ram_clk),
    .rst     (ram_rst),
    .enable  (wd_enable),
    .clear   (ram_rack),
    .expired (wd_expired)
  );

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (line_req) state_nxt = line_rnw ? RD_CMD : WR_DATA;
      RD_CMD:  state_nxt = RD_DATA;
      RD_DATA: if ((ram_rack && last_beat) || wd_expired) state_nxt = DONE;
      WR_DATA: if (last_beat) state_nxt = WR_ACK;
      WR_ACK:  if (ram_rack || wd_expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word to present in the next WR_DATA cycle.
  always_comb begin
    wdata_nxt = '0;
    if (accept) begin
      wdata_nxt = line_beat(line_wdata, '0);
    end else if (state == WR_DATA && !last_beat) begin
      wdata_nxt = line_beat(wdata_q, BEAT_W'(beat + 1'b1));
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      line_ready <= 1'b1;
      line_done  <= 1'b0;
      line_err   <= 1'b0;
      line_rdata <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_avalid <= 1'b0;
      ram_rnw    <= 1'b0;
      wdata_q    <= '0;
      beat       <= '0;
    end else begin
      line_ready <= (state_nxt == IDLE);
      line_done  <= (state_nxt == DONE);
      line_err   <= (state_nxt == DONE) && wd_expired;
      ram_avalid <= (state_nxt == RD_CMD) || (state_nxt == WR_DATA);
      ram_rnw    <= (state_nxt == RD_CMD);
      ram_wdata  <= (state_nxt == WR_DATA) ? wdata_nxt : '0;

      if (accept) begin
        ram_addr   <= line_addr;
        wdata_q    <= line_wdata;
        line_rdata <= '0;
        beat       <= '0;
      end else if (state == RD_DATA && ram_rack) begin
        line_rdata[int'(beat)*RAM_WORD_SIZE +: RAM_WORD_SIZE] <= ram_rdata;
        beat <= beat + 1'b1;
      end else if (state == WR_DATA) begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_line_bridge.sv
// Scoreboarded bench for ram_line_bridge: driver issues line requests, a RAM
// responder serves the bus, and a monitor checks each completion.
module tb_ram_line_bridge;
  import cache_pkg::*;

  localparam int TIMEOUT = 8;

  logic                     ram_clk = 1'b0;
  logic                     ram_rst = 1'b1;
  logic                     line_req = 1'b0;
  logic                     line_rnw = 1'b0;
  logic [ADDR_SIZE-1:0]     line_addr = '0;
  logic [LINE_WIDTH-1:0]    line_wdata = '0;
  logic                     line_ready, line_done, line_err;
  logic [LINE_WIDTH-1:0]    line_rdata;
  logic [ADDR_SIZE-1:0]     ram_addr;
  logic [RAM_WORD_SIZE-1:0] ram_wdata;
  logic                     ram_avalid, ram_rnw;
  logic [RAM_WORD_SIZE-1:0] ram_rdata = '0;
  logic                     ram_rack = 1'b0;
  bridge_state_t            dbg_state;

  ram_line_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .ram_clk(ram_clk), .ram_rst(ram_rst), .line_req(line_req), .line_rnw(line_rnw),
    .line_addr(line_addr), .line_wdata(line_wdata), .line_ready(line_ready),
    .line_done(line_done), .line_err(line_err), .line_rdata(line_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_avalid(ram_avalid),
    .ram_rnw(ram_rnw), .ram_rdata(ram_rdata), .ram_rack(ram_rack), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 ram_clk = ~ram_clk;

  int cyc = 0;
  always @(posedge ram_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before limit");
    $fatal(1);
  end

  typedef struct {
    logic                  rnw;
    logic [ADDR_SIZE-1:0]  addr;
    logic [LINE_WIDTH-1:0] wdata;
    int                    beats;  // read: beats RAM returns; write: 0 = never ack
  } cmd_t;

  cmd_t                  cmd_q[$];
  logic [LINE_WIDTH:0]   exp_q[$];   // {err, rdata}
  logic [LINE_WIDTH-1:0] model_mem [0:(1<<ADDR_SIZE)-1];
  logic [LINE_WIDTH-1:0] ram_mem   [0:(1<<ADDR_SIZE)-1];
  int  errors = 0;
  int  checks = 0;
  int  last_ack_cyc = 0;
  bit  xfer_abort = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (line_ready !== 1'b1 && n < 200) begin
      @(negedge ram_clk);
      n++;
    end
    check("ready_wait", line_ready, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge ram_clk);
      n++;
    end
    check("idle_wait", exp_q.size(), 0);
    wait_ready();
  endtask

  // Reference model: a read returns the stored line up to the beats the RAM
  // delivers, the rest zero, with err when fewer than BEATS arrive; a write
  // reports a zero line and err only when the RAM never acknowledges.
  task automatic issue(input logic rnw, input logic [ADDR_SIZE-1:0] addr,
                       input logic [LINE_WIDTH-1:0] wdata, input int beats);
    logic [LINE_WIDTH-1:0] stored;
    logic [LINE_WIDTH-1:0] exp_data;
    logic                  exp_err;
    wait_ready();
    exp_data = '0;
    if (rnw) begin
      stored = model_mem[addr];
      for (int b = 0; b < beats; b++) exp_data[b*16 +: 16] = stored[b*16 +: 16];
      exp_err = (beats < BEATS);
    end else begin
      exp_err = (beats == 0);
      if (!exp_err) model_mem[addr] = wdata;
    end
    cmd_q.push_back('{rnw, addr, wdata, beats});
    exp_q.push_back({exp_err, exp_data});
    line_req   = 1'b1;
    line_rnw   = rnw;
    line_addr  = addr;
    line_wdata = wdata;
    @(negedge ram_clk);
    line_req = 1'b0;
  endtask

  // ---------------- RAM responder ----------------
  task automatic serve_read(input cmd_t cmd);
    logic [LINE_WIDTH-1:0] data;
    data = ram_mem[cmd.addr];
    last_ack_cyc = cyc + 1;
    @(negedge ram_clk);
    check("rd_cmd_one_cycle", ram_avalid, 1'b0);
    for (int b = 0; b < cmd.beats; b++) begin
      repeat ($urandom_range(0, 5)) @(negedge ram_clk);
      ram_rack  = 1'b1;
      ram_rdata = data[b*16 +: 16];
      last_ack_cyc = cyc + 1;
      @(negedge ram_clk);
      ram_rack = 1'b0;
    end
    if (cmd.beats == BEATS && $urandom_range(0, 2) == 0) begin
      ram_rack  = 1'b1;  // surplus ack, lands while the bridge is finishing
      ram_rdata = 16'($urandom);
      @(negedge ram_clk);
      ram_rack = 1'b0;
    end
  endtask

  task automatic serve_write(input cmd_t cmd);
    logic [LINE_WIDTH-1:0] got;
    got = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (b > 0) begin
        @(negedge ram_clk);
        if (xfer_abort) begin
          ram_rack = 1'b0;
          return;
        end
        check("wr_avalid", ram_avalid, 1'b1);
        check("wr_rnw", ram_rnw, 1'b0);
        check("wr_addr", ram_addr, cmd.addr);
      end
      check("wr_beat", ram_wdata, cmd.wdata[b*16 +: 16]);
      got[b*16 +: 16] = ram_wdata;
      ram_rack  = 1'($urandom_range(0, 1));  // must be ignored while beats stream
      ram_rdata = 16'($urandom);
    end
    last_ack_cyc = cyc + 1;
    @(negedge ram_clk);
    ram_rack = 1'b0;
    if (xfer_abort) return;
    check("wr_ack_avalid", ram_avalid, 1'b0);
    if (cmd.beats == 0) return;
    repeat ($urandom_range(0, 5)) @(negedge ram_clk);
    ram_rack = 1'b1;
    last_ack_cyc = cyc + 1;
    ram_mem[cmd.addr] = got;
    @(negedge ram_clk);
    ram_rack = 1'b0;
  endtask

  initial begin
    cmd_t cmd;
    forever begin
      @(negedge ram_clk);
      if (ram_avalid === 1'b1 && !xfer_abort) begin
        check("busy_ready", line_ready, 1'b0);
        if (cmd_q.size() == 0) begin
          fail("unexpected_cmd", "got a RAM command, required none");
        end else begin
          cmd = cmd_q.pop_front();
          check("cmd_rnw", ram_rnw, cmd.rnw);
          check("cmd_addr", ram_addr, cmd.addr);
          if (cmd.rnw) serve_read(cmd);
          else serve_write(cmd);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [LINE_WIDTH:0] e;
    logic prev_done = 1'b0;
    forever begin
      @(negedge ram_clk);
      if (ram_rst === 1'b0) begin
        if (line_done === 1'b1) begin
          check("done_pulse_width", prev_done, 1'b0);
          if (exp_q.size() == 0) begin
            fail("unexpected_done", "got line_done=1, required 0");
          end else begin
            e = exp_q.pop_front();
            check("done_err", line_err, e[LINE_WIDTH]);
            check("done_rdata", line_rdata, e[LINE_WIDTH-1:0]);
            check("done_latency", cyc - last_ack_cyc, e[LINE_WIDTH] ? TIMEOUT : 0);
          end
        end
        prev_done = line_done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [LINE_WIDTH-1:0] v;
    logic [LINE_WIDTH-1:0] saved;
    logic                  rnw;
    int                    roll;
    for (int i = 0; i < (1 << ADDR_SIZE); i++) begin
      v = {$urandom, $urandom};
      model_mem[i] = v;
      ram_mem[i]   = v;
    end
    repeat (3) @(negedge ram_clk);
    check("rst_line_ready", line_ready, 1'b1);
    check("rst_line_done", line_done, 1'b0);
    check("rst_line_err", line_err, 1'b0);
    check("rst_line_rdata", line_rdata, '0);
    check("rst_ram_avalid", ram_avalid, 1'b0);
    check("rst_ram_rnw", ram_rnw, 1'b0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_ram_wdata", ram_wdata, '0);
    #2 ram_rst = 1'b0;
    @(negedge ram_clk);

    // directed read
    model_mem[13'h0101] = 64'h300020001000080f;
    ram_mem[13'h0101]   = 64'h300020001000080f;
    issue(1'b1, 13'h0101, '0, 4);
    wait_idle();
    check("rdata_hold", line_rdata, 64'h300020001000080f);

    // directed write, then RAM content
    issue(1'b0, 13'h0181, 64'h300020001000181f, 4);
    wait_idle();
    check("ram_backdoor", ram_mem[13'h0181], 64'h300020001000181f);

    // RAM goes silent after two beats, then a normal read
    model_mem[13'h0202] = 64'h300020001000080f;
    ram_mem[13'h0202]   = 64'h300020001000080f;
    issue(1'b1, 13'h0202, '0, 2);
    wait_idle();
    check("timeout_rdata", line_rdata, 64'h000000001000080f);
    issue(1'b1, 13'h0181, '0, 4);
    wait_idle();

    // request pulsed while busy, spurious ack while idle
    issue(1'b1, 13'h0300, '0, 4);
    @(negedge ram_clk);
    check("busy_no_ready", line_ready, 1'b0);
    line_req = 1'b1; line_rnw = 1'b0; line_addr = 13'h1fff;
    @(negedge ram_clk);
    line_req = 1'b0;
    wait_idle();
    ram_rack = 1'b1;
    @(negedge ram_clk);
    ram_rack = 1'b0;
    check("idle_ack_ready", line_ready, 1'b1);
    @(negedge ram_clk);
    check("idle_ack_no_cmd", ram_avalid, 1'b0);
    check("idle_ack_ready2", line_ready, 1'b1);

    // reset in the middle of a write
    saved = model_mem[13'h0444];
    issue(1'b0, 13'h0444, {$urandom, $urandom}, 4);
    @(negedge ram_clk);
    @(negedge ram_clk);
    check("beat2_valid", ram_avalid, 1'b1);
    #2 ram_rst = 1'b1;
    xfer_abort = 1'b1;
    #1;
    check("arst_line_ready", line_ready, 1'b1);
    check("arst_ram_avalid", ram_avalid, 1'b0);
    check("arst_ram_wdata", ram_wdata, '0);
    check("arst_ram_addr", ram_addr, '0);
    check("arst_line_done", line_done, 1'b0);
    check("arst_line_err", line_err, 1'b0);
    check("arst_state", dbg_state, IDLE);
    exp_q.delete();
    cmd_q.delete();
    model_mem[13'h0444] = saved;
    repeat (2) @(negedge ram_clk);
    #2 ram_rst = 1'b0;
    @(negedge ram_clk);
    xfer_abort = 1'b0;
    check("post_rst_ready", line_ready, 1'b1);
    issue(1'b1, 13'h0101, '0, 4);
    wait_idle();

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      rnw  = 1'($urandom_range(0, 1));
      roll = $urandom_range(0, 9);
      if (rnw)
        issue(1'b1, 13'($urandom_range(0, 63)), '0, (roll < 2) ? $urandom_range(0, 3) : 4);
      else
        issue(1'b0, 13'($urandom_range(0, 63)), {$urandom, $urandom}, (roll < 1) ? 0 : 4);
    end
    wait_idle();
    check("exp_q_drained", exp_q.size(), 0);
    check("cmd_q_drained", cmd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
